// File: rtl/nasti_wr_sched_if.sv
// ---------------------------------------------------------------------------
// nasti_wr_sched_if
// Control-side bundle between the write scheduler of an N-to-1 NASTI mux and
// its surroundings (upstream AW request lines, downstream handshakes, and the
// select/enable lines that steer the write datapath mux).
//
// Parameters: PORTS (upstream ports), ID_WIDTH (AXI ID width).
// Signals:
//   req_valid[PORTS]          per-port aw_valid
//   req_id[PORTS*ID_WIDTH]    per-port aw_id, port p at [p*ID_WIDTH +: ID_WIDTH]
//   req_qos[PORTS*4]          per-port aw_qos
//   aw_ready, w_fire, w_last  downstream AW/W handshake status
//   b_valid, b_ready, b_id    downstream B channel / selected port's b_ready
//   sel, aw_en, w_en          datapath mux controls for AW/W
//   b_port, b_hit             B routing result
//   full                      outstanding-write table full
// Modports: master = the scheduler, slave = the environment driving it.
// ---------------------------------------------------------------------------
interface nasti_wr_sched_if #(
    parameter int PORTS    = 8,
    parameter int ID_WIDTH = 1
);
    localparam int SEL_W = $clog2(PORTS);

    logic [PORTS-1:0]          req_valid;
    logic [PORTS*ID_WIDTH-1:0] req_id;
    logic [PORTS*4-1:0]        req_qos;
    logic                      aw_ready;
    logic                      w_fire;
    logic                      w_last;
    logic                      b_valid;
    logic                      b_ready;
    logic [ID_WIDTH-1:0]       b_id;
    logic [SEL_W-1:0]          sel;
    logic                      aw_en;
    logic                      w_en;
    logic [SEL_W-1:0]          b_port;
    logic                      b_hit;
    logic                      full;

    modport master (
        input  req_valid, req_id, req_qos, aw_ready, w_fire, w_last,
               b_valid, b_ready, b_id,
        output sel, aw_en, w_en, b_port, b_hit, full
    );

    modport slave (
        output req_valid, req_id, req_qos, aw_ready, w_fire, w_last,
               b_valid, b_ready, b_id,
        input  sel, aw_en, w_en, b_port, b_hit, full
    );
endinterface

// File: rtl/nasti_wr_sched.sv
// ---------------------------------------------------------------------------
// nasti_wr_sched
// Write-path controller for an N-to-1 NASTI multiplexer. Round-robin AW
// arbitration, grant held through the W burst, an ID/port table of
// outstanding writes used to steer B responses and to block grants that
// would reorder responses of one ID across two ports. Carries no datapath.
//
// Ports:
//   clk  clock
//   rst  asynchronous reset, active-high
//   bus  nasti_wr_sched_if.master (requests, handshakes, mux controls)
//
// Optional feature: define NASTI_WR_SCHED_QOS_EN to restrict arbitration to
// the eligible ports with the highest req_qos (round-robin among ties).
// Without it req_qos is ignored.
// ---------------------------------------------------------------------------
module nasti_wr_sched #(
    parameter int PORTS     = 8,
    parameter int W_MAX     = 2,
    parameter int ID_WIDTH  = 1,
    parameter int LITE_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    nasti_wr_sched_if.master bus
);
    localparam int SEL_W = $clog2(PORTS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [W_MAX-1:0]    valid_q, valid_d;
    logic [ID_WIDTH-1:0] ent_id_q   [W_MAX];
    logic [ID_WIDTH-1:0] ent_id_d   [W_MAX];
    logic [SEL_W-1:0]    ent_port_q [W_MAX];
    logic [SEL_W-1:0]    ent_port_d [W_MAX];

    logic                full;
    logic [PORTS-1:0]    hazard;
    logic [PORTS-1:0]    eligible;
    logic [PORTS-1:0]    cand;
    logic [SEL_W:0]      pick;
    logic [W_MAX-1:0]    rec_oh;
    logic [W_MAX-1:0]    ret_oh;
    logic                rec_en;
    logic                aw_en;
    logic                w_en;
    logic                b_hit;
    logic [SEL_W-1:0]    b_port;
    logic [ID_WIDTH-1:0] sel_id;

    // First set bit of cand at or after ptr, wrapping at PORTS.
    // Returns {found, index}.
    function automatic logic [SEL_W:0] rr_pick(input logic [PORTS-1:0] c,
                                               input logic [SEL_W-1:0] ptr);
        logic [SEL_W:0] res;
        int             p;
        res = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            p = (int'(ptr) + k) % PORTS;
            if (c[SEL_W'(p)]) res = {1'b1, SEL_W'(p)};
        end
        return res;
    endfunction

    assign full = &valid_q;

    // A port is blocked while its ID is outstanding from a different port.
    always_comb begin
        hazard = '0;
        for (int p = 0; p < PORTS; p++) begin
            for (int e = 0; e < W_MAX; e++) begin
                if (valid_q[e] &&
                    ent_id_q[e] == bus.req_id[p*ID_WIDTH +: ID_WIDTH] &&
                    ent_port_q[e] != SEL_W'(p))
                    hazard[p] = 1'b1;
            end
        end
        eligible = bus.req_valid & ~hazard & {PORTS{~full}};
    end

`ifdef NASTI_WR_SCHED_QOS_EN
    logic [3:0] qos_max;
    always_comb begin
        qos_max = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (eligible[p] && bus.req_qos[p*4 +: 4] > qos_max)
                qos_max = bus.req_qos[p*4 +: 4];
        end
        for (int p = 0; p < PORTS; p++)
            cand[p] = eligible[p] && (bus.req_qos[p*4 +: 4] == qos_max);
    end
`else
    logic unused_qos;
    assign unused_qos = ^bus.req_qos;
    assign cand       = eligible;
`endif

    // Record slot comes from pre-cycle valid bits, so a slot retired in the
    // same cycle is never reused until the following cycle.
    always_comb begin
        rec_oh = '0;
        for (int e = W_MAX - 1; e >= 0; e--) begin
            if (!valid_q[e]) begin
                rec_oh    = '0;
                rec_oh[e] = 1'b1;
            end
        end
    end

    // B match: lowest-index valid entry with the returning ID.
    always_comb begin
        ret_oh = '0;
        b_port = '0;
        for (int e = W_MAX - 1; e >= 0; e--) begin
            if (bus.b_valid && valid_q[e] && ent_id_q[e] == bus.b_id) begin
                ret_oh    = '0;
                ret_oh[e] = 1'b1;
                b_port    = ent_port_q[e];
            end
        end
        b_hit = |ret_oh;
    end

    assign sel_id = bus.req_id[sel_q*ID_WIDTH +: ID_WIDTH];

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        rec_en   = 1'b0;
        aw_en    = 1'b0;
        w_en     = 1'b0;
        pick     = rr_pick(cand, rr_ptr_q);
        case (state_q)
            IDLE: begin
                if (pick[SEL_W]) begin
                    sel_d    = pick[SEL_W-1:0];
                    rr_ptr_d = (pick[SEL_W-1:0] == SEL_W'(PORTS - 1)) ?
                               '0 : pick[SEL_W-1:0] + SEL_W'(1);
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                aw_en = 1'b1;
                if (bus.req_valid[sel_q] && bus.aw_ready) begin
                    rec_en  = |rec_oh;
                    state_d = DATA;
                end else if (!bus.req_valid[sel_q]) begin
                    // aw_valid withdrawn before the handshake: drop the grant.
                    state_d = IDLE;
                end
            end
            DATA: begin
                w_en = 1'b1;
                if (bus.w_fire && (bus.w_last || LITE_MODE != 0))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        ent_id_d   = ent_id_q;
        ent_port_d = ent_port_q;
        if (bus.b_valid && bus.b_ready && b_hit)
            valid_d = valid_d & ~ret_oh;
        if (rec_en) begin
            valid_d = valid_d | rec_oh;
            for (int e = 0; e < W_MAX; e++) begin
                if (rec_oh[e]) begin
                    ent_id_d[e]   = sel_id;
                    ent_port_d[e] = sel_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
        end
    end

    // Entry payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_id_q   <= ent_id_d;
        ent_port_q <= ent_port_d;
    end

    assign bus.sel    = sel_q;
    assign bus.aw_en  = aw_en;
    assign bus.w_en   = w_en;
    assign bus.b_port = b_port;
    assign bus.b_hit  = b_hit;
    assign bus.full   = full;
endmodule

// File: tb/tb_nasti_wr_sched.sv
// ---------------------------------------------------------------------------
// tb_nasti_wr_sched
// Directed bench for nasti_wr_sched. dut_a: PORTS=8, W_MAX=2, ID_WIDTH=1,
// LITE_MODE=0. dut_b: same but LITE_MODE=1. Inputs change 1 time unit after
// the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_nasti_wr_sched;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    nasti_wr_sched_if #(.PORTS(8), .ID_WIDTH(1)) bus_a ();
    nasti_wr_sched_if #(.PORTS(8), .ID_WIDTH(1)) bus_b ();

    nasti_wr_sched #(.PORTS(8), .W_MAX(2), .ID_WIDTH(1), .LITE_MODE(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    nasti_wr_sched #(.PORTS(8), .W_MAX(2), .ID_WIDTH(1), .LITE_MODE(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_a.req_valid = '0; bus_a.req_id = '0; bus_a.req_qos = '0;
        bus_a.aw_ready  = 1'b0; bus_a.w_fire = 1'b0; bus_a.w_last = 1'b0;
        bus_a.b_valid   = 1'b0; bus_a.b_ready = 1'b0; bus_a.b_id = '0;
        bus_b.req_valid = '0; bus_b.req_id = '0; bus_b.req_qos = '0;
        bus_b.aw_ready  = 1'b0; bus_b.w_fire = 1'b0; bus_b.w_last = 1'b0;
        bus_b.b_valid   = 1'b0; bus_b.b_ready = 1'b0; bus_b.b_id = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        clear_inputs();
        tick();
        check("rst_sel",    32'(bus_a.sel),    32'd0);
        check("rst_aw_en",  32'(bus_a.aw_en),  32'd0);
        check("rst_w_en",   32'(bus_a.w_en),   32'd0);
        check("rst_b_port", 32'(bus_a.b_port), 32'd0);
        check("rst_b_hit",  32'(bus_a.b_hit),  32'd0);
        check("rst_full",   32'(bus_a.full),   32'd0);

        // Single write on port 2, then its B.
        do_reset();
        bus_a.req_valid = 8'b0000_0100;
        bus_a.aw_ready  = 1'b1;
        tick();
        check("t1_sel",   32'(bus_a.sel),   32'd2);
        check("t1_aw_en", 32'(bus_a.aw_en), 32'd1);
        check("t1_w_en0", 32'(bus_a.w_en),  32'd0);
        tick();
        check("t1_w_en",   32'(bus_a.w_en),  32'd1);
        check("t1_aw_en0", 32'(bus_a.aw_en), 32'd0);
        bus_a.req_valid = '0;
        bus_a.w_fire = 1'b1; bus_a.w_last = 1'b1;
        tick();
        check("t1_idle_w_en", 32'(bus_a.w_en), 32'd0);
        bus_a.w_fire = 1'b0; bus_a.w_last = 1'b0;
        bus_a.b_valid = 1'b1; bus_a.b_id = 1'b0; bus_a.b_ready = 1'b1;
        #1;
        check("t1_b_hit",  32'(bus_a.b_hit),  32'd1);
        check("t1_b_port", 32'(bus_a.b_port), 32'd2);
        tick();
        check("t1_b_hit_after", 32'(bus_a.b_hit), 32'd0);
        check("t1_full_after",  32'(bus_a.full),  32'd0);
        bus_a.b_valid = 1'b0;

        // Round-robin 0,3,5,0 with full blocking. ids: p0=0, p3=1, p5=0.
        do_reset();
        bus_a.req_valid = 8'b0010_1001;
        bus_a.req_id    = 8'b0000_1000;
        bus_a.aw_ready  = 1'b1;
        bus_a.w_fire    = 1'b1;
        bus_a.w_last    = 1'b1;
        tick();
        check("t2_g1", 32'(bus_a.sel), 32'd0);
        tick();
        tick();
        tick();
        check("t2_g2", 32'(bus_a.sel), 32'd3);
        tick();
        check("t2_full", 32'(bus_a.full), 32'd1);
        tick();
        tick();
        check("t2_no_grant_a", 32'(bus_a.aw_en), 32'd0);
        tick();
        check("t2_no_grant_b", 32'(bus_a.aw_en), 32'd0);
        check("t2_sel_hold",   32'(bus_a.sel),   32'd3);
        bus_a.b_valid = 1'b1; bus_a.b_id = 1'b0; bus_a.b_ready = 1'b1;
        #1;
        check("t2_b_port0", 32'(bus_a.b_port), 32'd0);
        tick();
        bus_a.b_valid = 1'b0;
        check("t2_not_full", 32'(bus_a.full), 32'd0);
        tick();
        check("t2_g3",    32'(bus_a.sel),   32'd5);
        check("t2_g3_aw", 32'(bus_a.aw_en), 32'd1);
        tick();
        tick();
        bus_a.b_valid = 1'b1; bus_a.b_id = 1'b0; bus_a.b_ready = 1'b1;
        #1;
        check("t2_b_port5", 32'(bus_a.b_port), 32'd5);
        tick();
        bus_a.b_valid = 1'b0;
        tick();
        check("t2_g4", 32'(bus_a.sel), 32'd0);
        tick();
        bus_a.req_valid = '0;

        // ID hazard: port 1 holds id 1; port 4 (id 1) waits, port 6 (id 0) goes.
        do_reset();
        bus_a.req_valid = 8'b0000_0010;
        bus_a.req_id    = 8'b0000_0010;
        bus_a.aw_ready  = 1'b1;
        bus_a.w_fire    = 1'b1;
        bus_a.w_last    = 1'b1;
        tick();
        tick();
        bus_a.req_valid = '0;
        tick();
        bus_a.req_valid = 8'b0101_0000;
        bus_a.req_id    = 8'b0001_0000;
        tick();
        check("t3_g6", 32'(bus_a.sel), 32'd6);
        tick();
        bus_a.req_valid = 8'b0001_0000;
        tick();
        bus_a.b_valid = 1'b1; bus_a.b_id = 1'b0; bus_a.b_ready = 1'b1;
        #1;
        check("t3_b_port6", 32'(bus_a.b_port), 32'd6);
        tick();
        bus_a.b_valid = 1'b0;
        tick();
        check("t3_p4_blocked_a", 32'(bus_a.aw_en), 32'd0);
        tick();
        check("t3_p4_blocked_b", 32'(bus_a.aw_en), 32'd0);
        bus_a.b_valid = 1'b1; bus_a.b_id = 1'b1; bus_a.b_ready = 1'b1;
        #1;
        check("t3_b_port1", 32'(bus_a.b_port), 32'd1);
        tick();
        bus_a.b_valid = 1'b0;
        check("t3_p4_blocked_c", 32'(bus_a.aw_en), 32'd0);
        tick();
        check("t3_g4",    32'(bus_a.sel),   32'd4);
        check("t3_g4_aw", 32'(bus_a.aw_en), 32'd1);

        // 4-beat burst on port 0 with port 1 waiting (LITE_MODE=0).
        do_reset();
        bus_a.req_valid = 8'b0000_0011;
        bus_a.req_id    = 8'b0000_0010;
        bus_a.aw_ready  = 1'b1;
        tick();
        check("t4_g0", 32'(bus_a.sel), 32'd0);
        tick();
        bus_a.req_valid = 8'b0000_0010;
        bus_a.w_fire    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t4_w_en_beat", 32'(bus_a.w_en), 32'd1);
            check("t4_sel_beat",  32'(bus_a.sel),  32'd0);
            tick();
        end
        bus_a.w_last = 1'b1;
        check("t4_w_en_last", 32'(bus_a.w_en), 32'd1);
        check("t4_sel_last",  32'(bus_a.sel),  32'd0);
        tick();
        check("t4_released", 32'(bus_a.w_en), 32'd0);
        bus_a.w_fire = 1'b0; bus_a.w_last = 1'b0;
        tick();
        check("t4_g1",    32'(bus_a.sel),   32'd1);
        check("t4_g1_aw", 32'(bus_a.aw_en), 32'd1);

        // Same with LITE_MODE=1: grant released after the first beat.
        do_reset();
        bus_b.req_valid = 8'b0000_0011;
        bus_b.req_id    = 8'b0000_0010;
        bus_b.aw_ready  = 1'b1;
        tick();
        check("t4l_g0", 32'(bus_b.sel), 32'd0);
        tick();
        check("t4l_w_en", 32'(bus_b.w_en), 32'd1);
        bus_b.req_valid = 8'b0000_0010;
        bus_b.w_fire    = 1'b1;
        tick();
        check("t4l_released", 32'(bus_b.w_en), 32'd0);
        bus_b.w_fire = 1'b0;
        tick();
        check("t4l_g1", 32'(bus_b.sel), 32'd1);

        // Same-cycle record and retire: entry 0 retires while AW records.
        do_reset();
        bus_a.req_valid = 8'b0000_0001;
        bus_a.aw_ready  = 1'b1;
        bus_a.w_fire    = 1'b1;
        bus_a.w_last    = 1'b1;
        tick();
        tick();
        bus_a.req_valid = '0;
        tick();
        bus_a.req_valid = 8'b0000_0100;
        bus_a.req_id    = 8'b0000_0100;
        tick();
        check("t5_addr", 32'(bus_a.aw_en), 32'd1);
        bus_a.b_valid = 1'b1; bus_a.b_id = 1'b0; bus_a.b_ready = 1'b1;
        #1;
        check("t5_ret_port", 32'(bus_a.b_port), 32'd0);
        tick();
        bus_a.b_valid = 1'b0;
        check("t5_full0", 32'(bus_a.full), 32'd0);
        bus_a.b_valid = 1'b1; bus_a.b_id = 1'b1; bus_a.b_ready = 1'b0;
        #1;
        check("t5_new_hit",  32'(bus_a.b_hit),  32'd1);
        check("t5_new_port", 32'(bus_a.b_port), 32'd2);
        bus_a.b_id = 1'b0;
        #1;
        check("t5_old_gone",  32'(bus_a.b_hit),  32'd0);
        check("t5_old_port0", 32'(bus_a.b_port), 32'd0);
        bus_a.b_valid = 1'b0;
        tick();
        tick();
        check("t5_regrant", 32'(bus_a.sel), 32'd2);
        tick();
        check("t5_full1", 32'(bus_a.full), 32'd1);
        bus_a.req_valid = '0;
        tick();

        // Reset asserted mid-DATA clears outputs at once.
        do_reset();
        bus_a.req_valid = 8'b0010_0000;
        bus_a.aw_ready  = 1'b1;
        tick();
        tick();
        check("t5r_w_en", 32'(bus_a.w_en), 32'd1);
        check("t5r_sel",  32'(bus_a.sel),  32'd5);
        bus_a.b_valid = 1'b1; bus_a.b_id = 1'b0;
        #1;
        check("t5r_b_port_pre", 32'(bus_a.b_port), 32'd5);
        #1;
        rst = 1'b1;
        #1;
        check("t5r_sel0",    32'(bus_a.sel),    32'd0);
        check("t5r_w_en0",   32'(bus_a.w_en),   32'd0);
        check("t5r_aw_en0",  32'(bus_a.aw_en),  32'd0);
        check("t5r_b_hit0",  32'(bus_a.b_hit),  32'd0);
        check("t5r_b_port0", 32'(bus_a.b_port), 32'd0);
        check("t5r_full0",   32'(bus_a.full),   32'd0);

        // QoS: port 1 qos 2 (id 0), port 3 qos 7 (id 1).
        do_reset();
        bus_a.req_valid = 8'b0000_1010;
        bus_a.req_id    = 8'b0000_1000;
        bus_a.req_qos   = 32'h0000_7020;
        bus_a.aw_ready  = 1'b1;
        bus_a.w_fire    = 1'b1;
        bus_a.w_last    = 1'b1;
        tick();
`ifdef NASTI_WR_SCHED_QOS_EN
        check("t6_first", 32'(bus_a.sel), 32'd3);
`else
        check("t6_first", 32'(bus_a.sel), 32'd1);
`endif
        tick();
        tick();
        tick();
        check("t6_second", 32'(bus_a.sel), 32'd3);
        tick();
        tick();
        bus_a.req_qos = 32'h0000_5050;
        bus_a.b_valid = 1'b1; bus_a.b_id = 1'b1; bus_a.b_ready = 1'b1;
        #1;
        check("t6_b_port", 32'(bus_a.b_port), 32'd3);
        tick();
        bus_a.b_valid = 1'b0;
        tick();
        check("t6_tie_rr", 32'(bus_a.sel), 32'd1);
        clear_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
